// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states and the reject rule.
package alu_pkg;
  localparam int LATIME_DEF = 32;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MAX = OP_SHR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RASP = 2'd2
  } state_t;

  // Operations the ALU must never see: unknown opcodes and division by zero.
  function automatic logic op_rejected(input logic [3:0] op, input logic b_zero);
    return (op > OP_MAX) || ((op == OP_DIV) && b_zero);
  endfunction
endpackage

// File: rtl/alu_arbitru_if.sv
// Request, response and ALU-side signals of the arbiter; slave = arbiter, master = requesters/ALU.
interface alu_arbitru_if
  import alu_pkg::*;
#(
  parameter int LATIME = LATIME_DEF
);
  logic              req0_valid, req0_ready;
  logic [LATIME-1:0] req0_A, req0_B;
  logic [3:0]        req0_operatie;
  logic              req1_valid, req1_ready;
  logic [LATIME-1:0] req1_A, req1_B;
  logic [3:0]        req1_operatie;

  logic              resp0_valid, resp0_ready;
  logic              resp1_valid, resp1_ready;
  logic [LATIME-1:0] resp_rezultat, resp_rest;
  logic              resp_zero, resp_eroare;

  logic [LATIME-1:0] alu_A, alu_B;
  logic [3:0]        alu_operatie;
  logic [LATIME-1:0] alu_rezultat, alu_rest;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_operatie,
    input  req1_valid, req1_A, req1_B, req1_operatie,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_rezultat, resp_rest, resp_zero, resp_eroare,
    input  resp0_ready, resp1_ready,
    output alu_A, alu_B, alu_operatie,
    input  alu_rezultat, alu_rest, alu_zero
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_operatie,
    output req1_valid, req1_A, req1_B, req1_operatie,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_rezultat, resp_rest, resp_zero, resp_eroare,
    output resp0_ready, resp1_ready,
    input  alu_A, alu_B, alu_operatie,
    output alu_rezultat, alu_rest, alu_zero
  );
endinterface

// File: rtl/arbitru_rr.sv
// Two-way round-robin grant: pointer holder wins ties, pointer passes to the other side on accept.
module arbitru_rr (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  input  logic accept,
  output logic grant,
  output logic grant_vld,
  output logic ptr_next
);
  assign grant_vld = valid0 | valid1;
  assign grant     = (valid0 && valid1) ? ptr : valid1;
  assign ptr_next  = accept ? ~grant : ptr;
endmodule

// File: rtl/alu_arbitru.sv
// Arbitrates two requesters onto one shared combinational ALU, holds its inputs for
// LATENTA_ALU cycles, then returns the captured result until the owner takes it.
module alu_arbitru
  import alu_pkg::*;
#(
  parameter int LATIME      = LATIME_DEF,
  parameter int LATENTA_ALU = 1
) (
  input logic         clk,
  input logic         rst,
  alu_arbitru_if.slave bus
);
  localparam logic [3:0] LAT_INIT = 4'(LATENTA_ALU);

  state_t            state, state_nxt;
  logic              ptr, ptr_nxt, owner;
  logic              grant, grant_vld, accept, reject;
  logic [LATIME-1:0] in_a, in_b, a_q, b_q;
  logic [3:0]        in_op, op_q, cnt;
  logic [LATIME-1:0] rez_q, rest_q;
  logic              zero_q, err_q;

  arbitru_rr u_rr (
    .valid0    (bus.req0_valid),
    .valid1    (bus.req1_valid),
    .ptr       (ptr),
    .accept    (accept),
    .grant     (grant),
    .grant_vld (grant_vld),
    .ptr_next  (ptr_nxt)
  );

  assign accept = !rst && (state == IDLE) && grant_vld;
  assign in_a   = grant ? bus.req1_A : bus.req0_A;
  assign in_b   = grant ? bus.req1_B : bus.req0_B;
  assign in_op  = grant ? bus.req1_operatie : bus.req0_operatie;
  assign reject = op_rejected(in_op, in_b == '0);

  assign bus.resp_rezultat = rez_q;
  assign bus.resp_rest     = rest_q;
  assign bus.resp_zero     = zero_q;
  assign bus.resp_eroare   = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.req0_ready   = 1'b0;
    bus.req1_ready   = 1'b0;
    bus.resp0_valid  = 1'b0;
    bus.resp1_valid  = 1'b0;
    bus.alu_A        = '0;
    bus.alu_B        = '0;
    bus.alu_operatie = '0;
    case (state)
      IDLE: begin
        bus.req0_ready = !rst && grant_vld && !grant;
        bus.req1_ready = !rst && grant_vld && grant;
        if (accept) state_nxt = reject ? RASP : EXEC;
      end
      EXEC: begin
        bus.alu_A        = a_q;
        bus.alu_B        = b_q;
        bus.alu_operatie = op_q;
        if (cnt == 4'd1) state_nxt = RASP;
      end
      RASP: begin
        bus.resp0_valid = !owner;
        bus.resp1_valid = owner;
        if (owner ? bus.resp1_ready : bus.resp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      owner  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      rez_q  <= '0;
      rest_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
      if (accept) begin
        owner <= grant;
        a_q   <= in_a;
        b_q   <= in_b;
        op_q  <= in_op;
        cnt   <= LAT_INIT;
        if (reject) begin
          rez_q  <= '0;
          rest_q <= '0;
          zero_q <= 1'b0;
          err_q  <= 1'b1;
        end
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        // Sample on the last hold cycle; the remainder is only meaningful for division.
        if (cnt == 4'd1) begin
          rez_q  <= bus.alu_rezultat;
          rest_q <= (op_q == OP_DIV) ? bus.alu_rest : '0;
          zero_q <= bus.alu_zero;
          err_q  <= 1'b0;
        end
      end
    end
  end
endmodule
